task_stream_adapter: RTL

TASK_STREAM_ADAPTER -- requirements
Module: task_stream_adapter

---
 rtl/task_stream_adapter_if.sv | 47 ++++
 rtl/task_stream_adapter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/task_stream_adapter_if.sv
// Signal bundle around task_stream_adapter: task byte stream in, packed words
// to the core, core results back, packed answer words out to the manager.
//
// Handshake: a beat moves on a rising edge where the producer's valid and the
// consumer's ready are both high. The producer holds its data stable while
// valid is high and ready is low. The byte stream uses i_tdata_valid/o_tready.
// The answer channel uses o_tanswer_ready as its valid and i_tmanager_ready as
// its ready. The core channels (o_core_valid, i_core_valid) are one-cycle
// strobes with no backpressure.
interface task_stream_adapter_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
);
  logic             i_tdata_valid;
  logic [7:0]       i_tdata;
  logic             i_tdata_last;
  logic             o_tready;
  logic [IN_W-1:0]  o_core_data;
  logic             o_core_valid;
  logic [OUT_W-1:0] i_core_data;
  logic             i_core_valid;
  logic             i_tmanager_ready;
  logic             o_tanswer_ready;
  logic [31:0]      o_tanswer_data;
  logic             o_tanswer_data_last;
  logic [11:0]      o_packet_size_in_bytes;
  logic             o_overflow;
  logic [1:0]       o_state_dbg;

  // Adapter view
  modport slave (
    input  i_tdata_valid, i_tdata, i_tdata_last,
    input  i_core_data, i_core_valid, i_tmanager_ready,
    output o_tready, o_core_data, o_core_valid,
    output o_tanswer_ready, o_tanswer_data, o_tanswer_data_last,
    output o_packet_size_in_bytes, o_overflow, o_state_dbg
  );

  // Environment view: stream source, core and manager
  modport master (
    output i_tdata_valid, i_tdata, i_tdata_last,
    output i_core_data, i_core_valid, i_tmanager_ready,
    input  o_tready, o_core_data, o_core_valid,
    input  o_tanswer_ready, o_tanswer_data, o_tanswer_data_last,
    input  o_packet_size_in_bytes, o_overflow, o_state_dbg
  );
endinterface

// File: rtl/task_stream_adapter.sv
// Task stream adapter: packs incoming bytes into core words, buffers the core
// results of one packet, then streams them to the manager as 32-bit answers.
// FSM: IDLE -> RECV -> DRAIN -> SEND -> IDLE. State is visible on o_state_dbg.
module task_stream_adapter #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 16,
  parameter int DEPTH     = 256,
  parameter int MSB_FIRST = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  task_stream_adapter_if.slave  bus
);
  localparam int NB = IN_W / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int R  = 32 / OUT_W;
  localparam int OB = OUT_W / 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t           state;
  logic [BW-1:0]    byte_idx;
  logic [IN_W-1:0]  word_buf;
  logic [IN_W-1:0]  word_new;
  logic [CW-1:0]    n_in;
  logic [CW-1:0]    n_out;
  logic [CW-1:0]    n_out_next;
  logic [CW-1:0]    rd_base;
  logic [OUT_W-1:0] mem [DEPTH];
  logic [OUT_W-1:0] core_data;
  logic             accept;
  logic             in_full;
  logic             word_done;
  logic             wr_en;

  assign core_data       = bus.i_core_data;
  assign accept          = bus.i_tdata_valid && bus.o_tready;
  assign in_full         = (n_in == CW'(DEPTH));
  assign word_done       = (byte_idx == BW'(NB - 1)) || bus.i_tdata_last;
  // Results only land while a packet is open; IDLE/SEND arrivals and those
  // beyond the buffer are dropped.
  assign wr_en           = bus.i_core_valid && (state == RECV || state == DRAIN) &&
                           (n_out < CW'(DEPTH));
  assign n_out_next      = n_out + CW'(wr_en);
  assign bus.o_state_dbg = state;

  // Current partial word with the incoming byte dropped into its lane.
  always_comb begin
    word_new = word_buf;
    if (MSB_FIRST != 0) word_new[IN_W - 8 - 8 * int'(byte_idx) +: 8] = bus.i_tdata;
    else                word_new[8 * int'(byte_idx) +: 8] = bus.i_tdata;
  end

  // Gather R results starting at base into one answer word; slots past the
  // packet are zero. A result being written this very cycle is forwarded so
  // SEND can be entered in the same cycle as the final result.
  function automatic logic [31:0] pack_answer(input int base);
    logic [31:0]      w;
    logic [OUT_W-1:0] r;
    int               idx;
    w = '0;
    for (int k = 0; k < R; k++) begin
      idx = base + k;
      r   = '0;
      if (idx < int'(n_in)) begin
        if (wr_en && idx == int'(n_out)) r = core_data;
        else                             r = mem[idx[AW-1:0]];
      end
      if (MSB_FIRST != 0) w[32 - OUT_W - k * OUT_W +: OUT_W] = r;
      else                w[k * OUT_W +: OUT_W] = r;
    end
    return w;
  endfunction

  // Result buffer write port; contents beyond n_in are never read out.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[n_out[AW-1:0]] <= core_data;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state                      <= IDLE;
      byte_idx                   <= '0;
      word_buf                   <= '0;
      n_in                       <= '0;
      n_out                      <= '0;
      rd_base                    <= '0;
      bus.o_tready               <= 1'b1;
      bus.o_core_valid           <= 1'b0;
      bus.o_core_data            <= '0;
      bus.o_tanswer_ready        <= 1'b0;
      bus.o_tanswer_data         <= '0;
      bus.o_tanswer_data_last    <= 1'b0;
      bus.o_packet_size_in_bytes <= '0;
      bus.o_overflow             <= 1'b0;
    end else begin
      bus.o_core_valid <= 1'b0;
      if (wr_en) n_out <= n_out_next;
      case (state)
        IDLE, RECV: begin
          if (accept) begin
            if (in_full) begin
              // Buffer already promised DEPTH results: swallow bytes until last.
              bus.o_overflow <= 1'b1;
            end else if (word_done) begin
              bus.o_core_data  <= word_new;
              bus.o_core_valid <= 1'b1;
              n_in             <= n_in + CW'(1);
              word_buf         <= '0;
              byte_idx         <= '0;
            end else begin
              word_buf <= word_new;
              byte_idx <= byte_idx + BW'(1);
            end
            if (bus.i_tdata_last) begin
              state        <= DRAIN;
              bus.o_tready <= 1'b0;
            end else begin
              state <= RECV;
            end
          end
        end
        DRAIN: begin
          if (n_in == '0) begin
            state                      <= IDLE;
            bus.o_tready               <= 1'b1;
            bus.o_packet_size_in_bytes <= '0;
            bus.o_overflow             <= 1'b0;
            n_out                      <= '0;
          end else if (n_out_next == n_in) begin
            state                      <= SEND;
            bus.o_tanswer_ready        <= 1'b1;
            bus.o_tanswer_data         <= pack_answer(0);
            bus.o_tanswer_data_last    <= (R >= int'(n_in));
            bus.o_packet_size_in_bytes <= 12'(int'(n_in) * OB);
            rd_base                    <= '0;
          end
        end
        SEND: begin
          if (bus.i_tmanager_ready) begin
            if (bus.o_tanswer_data_last) begin
              state                   <= IDLE;
              bus.o_tready            <= 1'b1;
              bus.o_tanswer_ready     <= 1'b0;
              bus.o_tanswer_data      <= '0;
              bus.o_tanswer_data_last <= 1'b0;
              bus.o_overflow          <= 1'b0;
              n_in                    <= '0;
              n_out                   <= '0;
            end else begin
              rd_base                 <= CW'(int'(rd_base) + R);
              bus.o_tanswer_data      <= pack_answer(int'(rd_base) + R);
              bus.o_tanswer_data_last <= (int'(rd_base) + 2 * R >= int'(n_in));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
